// File: rtl/dma_priority_resolver_if.sv
// Bus bundle between the DMA channel arbiter and its environment (DREQ side,
// CPU hold handshake, timing-control handshake and grant outputs).
interface dma_priority_resolver_if;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       CS_N;
    logic       HLDA;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic [7:0] priorityOrder;

    modport slave (
        input  DREQ, maskReg, priorityType, CS_N, HLDA, serviceDone,
        output HRQ, DACK, grantValid, grantChannel, priorityOrder
    );

    modport master (
        output DREQ, maskReg, priorityType, CS_N, HLDA, serviceDone,
        input  HRQ, DACK, grantValid, grantChannel, priorityOrder
    );
endinterface

// File: rtl/dma_priority_resolver.sv
// Four-channel DMA arbiter: hold request to the CPU, one-hot grant once HLDA
// arrives, fixed or rotating priority, mandatory one-cycle bus release.
module dma_priority_resolver #(
    parameter int NUM_CH = 4
) (
    input logic                   CLK,
    input logic                   RESET_N,
    dma_priority_resolver_if.slave bus
);

    typedef enum logic [3:0] {
        SIDLE  = 4'b0001,
        SREQ   = 4'b0010,
        SGRANT = 4'b0100,
        SREL   = 4'b1000
    } state_t;

    localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] chan_r;
    logic [1:0] next_chan_s;
    logic [7:0] order_r;
    logic [7:0] next_order_s;
    logic [3:0] act_s;
    logic [1:0] winner_s;
    logic       hrq_r;
    logic [3:0] dack_r;
    logic       grant_valid_r;
    logic [1:0] grant_channel_r;

    // First channel in the priority list whose request is active.
    function automatic logic [1:0] pick_winner(input logic [3:0] act, input logic [7:0] order);
        logic [1:0] win;
        logic [1:0] ch;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch = order[2*i +: 2];
            if (!found && act[ch]) begin
                win   = ch;
                found = 1'b1;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Serviced channel k drops to lowest: field i becomes (k+1+i) mod 4.
    function automatic logic [7:0] rotate_order(input logic [1:0] k);
        logic [7:0] ord;
        ord = 8'd0;
        for (int i = 0; i < 4; i++) begin
            ord[2*i +: 2] = k + 2'd1 + 2'(i);
        end
        return ord;
    endfunction

    // Active request vector and the current arbitration winner.
    always_comb begin
        act_s    = bus.DREQ & ~bus.maskReg;
        winner_s = pick_winner(act_s, order_r);
    end

    // Next-state, channel latch and priority-order update.
    always_comb begin
        next_state_s = state_r;
        next_chan_s  = chan_r;
        next_order_s = bus.priorityType ? order_r : FIXED_ORDER;
        case (state_r)
            SIDLE: begin
                if ((act_s != 4'd0) && bus.CS_N) begin
                    next_state_s = SREQ;
                end else begin
                    next_state_s = SIDLE;
                end
            end
            SREQ: begin
                if (bus.HLDA && (act_s != 4'd0)) begin
                    next_state_s = SGRANT;
                    next_chan_s  = winner_s;
                end else if (!bus.HLDA && (act_s == 4'd0)) begin
                    next_state_s = SIDLE;
                end else begin
                    next_state_s = SREQ;
                end
            end
            SGRANT: begin
                // serviceDone takes precedence over a simultaneous HLDA drop
                if (bus.serviceDone) begin
                    next_state_s = SREL;
                    if (bus.priorityType) begin
                        next_order_s = rotate_order(chan_r);
                    end else begin
                        next_order_s = FIXED_ORDER;
                    end
                end else if (!bus.HLDA) begin
                    next_state_s = SIDLE;
                end else begin
                    next_state_s = SGRANT;
                end
            end
            SREL: begin
                next_state_s = SIDLE;
            end
            default: begin
                next_state_s = SIDLE;
            end
        endcase
    end

    // State, latched channel, priority order and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r         <= SIDLE;
            chan_r          <= 2'd0;
            order_r         <= FIXED_ORDER;
            hrq_r           <= 1'b0;
            dack_r          <= 4'd0;
            grant_valid_r   <= 1'b0;
            grant_channel_r <= 2'd0;
        end else begin
            state_r         <= next_state_s;
            chan_r          <= next_chan_s;
            order_r         <= next_order_s;
            hrq_r           <= (next_state_s == SREQ) || (next_state_s == SGRANT);
            dack_r          <= (next_state_s == SGRANT) ? (4'b0001 << next_chan_s) : 4'd0;
            grant_valid_r   <= (next_state_s == SGRANT);
            grant_channel_r <= (next_state_s == SGRANT) ? next_chan_s : 2'd0;
        end
    end

    assign bus.HRQ           = hrq_r;
    assign bus.DACK          = dack_r;
    assign bus.grantValid    = grant_valid_r;
    assign bus.grantChannel  = grant_channel_r;
    assign bus.priorityOrder = order_r;

endmodule
